uart_rx_frame_ctrl: RTL and testbench

//  Sequences the byte stream from the UART receiver (RX_DV/RX_Byte pair) into framed packets:

---
 rtl/uart_rx_frame_ctrl_if.sv | 28 ++
 rtl/uart_rx_frame_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_frame_ctrl_if.sv
// Byte-stream, frame handshake and payload read port of the UART frame controller.
// The master side is the UART receiver plus consumer; the slave side is the controller.
interface uart_rx_frame_ctrl_if #(
    parameter int MAX_LEN = 16
);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    logic          i_RX_DV;
    logic [7:0]    i_RX_Byte;
    logic          i_Frame_Ack;
    logic [AW-1:0] i_Rd_Addr;
    logic [7:0]    o_Rd_Data;
    logic          o_Frame_Valid;
    logic [7:0]    o_Frame_Len;
    logic          o_Err_Stb;
    logic [1:0]    o_Err_Code;
    logic          o_Busy;

    modport master (
        output i_RX_DV, i_RX_Byte, i_Frame_Ack, i_Rd_Addr,
        input  o_Rd_Data, o_Frame_Valid, o_Frame_Len, o_Err_Stb, o_Err_Code, o_Busy
    );

    modport slave (
        input  i_RX_DV, i_RX_Byte, i_Frame_Ack, i_Rd_Addr,
        output o_Rd_Data, o_Frame_Valid, o_Frame_Len, o_Err_Stb, o_Err_Code, o_Busy
    );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// Frames the UART receiver byte stream (SYNC, LEN, payload, CHK), buffers the payload,
// checks length and checksum, enforces an inter-byte timeout and holds each good frame
// until the consumer acknowledges it.
//
// state    | meaning
// HUNT     | waiting for SYNC_BYTE, other bytes dropped
// GET_LEN  | expecting the length byte
// GET_DATA | storing payload bytes, accumulating checksum
// GET_CHK  | expecting the checksum byte
// HOLD     | good frame held for the consumer until ack
module uart_rx_frame_ctrl #(
    parameter int         CLKS_PER_BIT = 2604,
    parameter int         TIMEOUT_BITS = 20,
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst,
    uart_rx_frame_ctrl_if.slave  bus
);
    localparam int         TIMEOUT_CLKS = CLKS_PER_BIT * TIMEOUT_BITS;
    localparam int         TW           = $clog2(TIMEOUT_CLKS + 1);
    localparam int         AW           = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B    = 8'(MAX_LEN);

    localparam logic [1:0] ERR_CHK     = 2'b00;
    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_OVERRUN = 2'b11;

    typedef enum logic [2:0] {
        HUNT     = 3'd0,
        GET_LEN  = 3'd1,
        GET_DATA = 3'd2,
        GET_CHK  = 3'd3,
        HOLD     = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [7:0]    len_q;
    logic [7:0]    sum_q;
    logic [AW-1:0] idx_q;
    logic [7:0]    idx_ext;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    frame_len_q;
    logic          err_stb_q;
    logic [1:0]    err_code_q;
    logic [7:0]    rd_data_q;
    logic [7:0]    mem [MAX_LEN];

    logic          in_frame;
    logic          tmo_hit;
    logic          err_fire;
    logic [1:0]    err_code_nxt;
    logic          ld_len;
    logic          wr_en;
    logic          ld_frame;

    assign idx_ext  = 8'(idx_q);
    assign in_frame = (state == GET_LEN) || (state == GET_DATA) || (state == GET_CHK);
    // A byte on the terminal-count cycle wins over the timeout.
    assign tmo_hit  = in_frame && !bus.i_RX_DV && (tmo_cnt == TW'(TIMEOUT_CLKS - 1));

    // State register.
    always_ff @(posedge i_Clock or posedge i_Rst) begin
        if (i_Rst) state <= HUNT;
        else       state <= state_nxt;
    end

    // Next-state decode plus the strobes that steer the datapath.
    always_comb begin
        state_nxt    = state;
        err_fire     = 1'b0;
        err_code_nxt = err_code_q;
        ld_len       = 1'b0;
        wr_en        = 1'b0;
        ld_frame     = 1'b0;
        case (state)
            HUNT: begin
                if (bus.i_RX_DV && (bus.i_RX_Byte == SYNC_BYTE)) state_nxt = GET_LEN;
            end
            GET_LEN: begin
                if (bus.i_RX_DV) begin
                    if ((bus.i_RX_Byte == 8'h00) || (bus.i_RX_Byte > MAX_LEN_B)) begin
                        err_fire     = 1'b1;
                        err_code_nxt = ERR_LEN;
                        state_nxt    = HUNT;
                    end else begin
                        ld_len    = 1'b1;
                        state_nxt = GET_DATA;
                    end
                end else if (tmo_hit) begin
                    err_fire     = 1'b1;
                    err_code_nxt = ERR_TIMEOUT;
                    state_nxt    = HUNT;
                end
            end
            GET_DATA: begin
                if (bus.i_RX_DV) begin
                    wr_en = 1'b1;
                    if (idx_ext == (len_q - 8'd1)) state_nxt = GET_CHK;
                end else if (tmo_hit) begin
                    err_fire     = 1'b1;
                    err_code_nxt = ERR_TIMEOUT;
                    state_nxt    = HUNT;
                end
            end
            GET_CHK: begin
                if (bus.i_RX_DV) begin
                    if (bus.i_RX_Byte == sum_q) begin
                        ld_frame  = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        err_fire     = 1'b1;
                        err_code_nxt = ERR_CHK;
                        state_nxt    = HUNT;
                    end
                end else if (tmo_hit) begin
                    err_fire     = 1'b1;
                    err_code_nxt = ERR_TIMEOUT;
                    state_nxt    = HUNT;
                end
            end
            HOLD: begin
                // Bytes arriving while a frame is held are dropped; the frame stays intact.
                if (bus.i_RX_DV) begin
                    err_fire     = 1'b1;
                    err_code_nxt = ERR_OVERRUN;
                end
                if (bus.i_Frame_Ack) state_nxt = HUNT;
            end
            default: state_nxt = HUNT;
        endcase
    end

    // Length, running checksum and payload index.
    always_ff @(posedge i_Clock or posedge i_Rst) begin
        if (i_Rst) begin
            len_q <= 8'h00;
            sum_q <= 8'h00;
            idx_q <= '0;
        end else if (ld_len) begin
            len_q <= bus.i_RX_Byte;
            sum_q <= bus.i_RX_Byte;
            idx_q <= '0;
        end else if (wr_en) begin
            sum_q <= sum_q + bus.i_RX_Byte;
            idx_q <= idx_q + AW'(1);
        end
    end

    // Inter-byte timer: idle outside the frame states, restarted by every byte.
    always_ff @(posedge i_Clock or posedge i_Rst) begin
        if (i_Rst)                      tmo_cnt <= '0;
        else if (!in_frame || bus.i_RX_DV) tmo_cnt <= '0;
        else                            tmo_cnt <= tmo_cnt + TW'(1);
    end

    // Held frame length and the error pulse / sticky code.
    always_ff @(posedge i_Clock or posedge i_Rst) begin
        if (i_Rst) begin
            frame_len_q <= 8'h00;
            err_stb_q   <= 1'b0;
            err_code_q  <= 2'b00;
        end else begin
            err_stb_q <= err_fire;
            if (err_fire) err_code_q  <= err_code_nxt;
            if (ld_frame) frame_len_q <= len_q;
        end
    end

    // Payload buffer; contents are deliberately not reset.
    always_ff @(posedge i_Clock) begin
        if (wr_en) mem[idx_q] <= bus.i_RX_Byte;
    end

    // Registered read port, usable in any state.
    always_ff @(posedge i_Clock or posedge i_Rst) begin
        if (i_Rst) rd_data_q <= 8'h00;
        else       rd_data_q <= mem[bus.i_Rd_Addr];
    end

    assign bus.o_Rd_Data     = rd_data_q;
    assign bus.o_Frame_Valid = (state == HOLD);
    assign bus.o_Frame_Len   = frame_len_q;
    assign bus.o_Err_Stb     = err_stb_q;
    assign bus.o_Err_Code    = err_code_q;
    assign bus.o_Busy        = (state != HUNT);
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl with a short timeout (4 clk/bit, 2 bits -> 8 clks).
module tb_uart_rx_frame_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   err_pulses = 0;
    int   snap;

    uart_rx_frame_ctrl_if #(.MAX_LEN(16)) bus ();

    uart_rx_frame_ctrl #(
        .CLKS_PER_BIT(4),
        .TIMEOUT_BITS(2),
        .MAX_LEN     (16),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .i_Clock(clk),
        .i_Rst  (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Count every error pulse seen, sampled away from the active edge.
    always @(negedge clk) if (bus.o_Err_Stb === 1'b1) err_pulses++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle strobe; returns on the negedge after the sampling edge.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.i_RX_DV   = 1'b1;
        bus.i_RX_Byte = b;
        @(negedge clk);
        bus.i_RX_DV   = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [3:0] a, input logic [7:0] exp);
        @(negedge clk);
        bus.i_Rd_Addr = a;
        @(negedge clk);
        chk(tag, 32'(bus.o_Rd_Data), 32'(exp));
    endtask

    task automatic ack();
        @(negedge clk);
        bus.i_Frame_Ack = 1'b1;
        @(negedge clk);
        bus.i_Frame_Ack = 1'b0;
    endtask

    initial begin
        bus.i_RX_DV     = 1'b0;
        bus.i_RX_Byte   = 8'h00;
        bus.i_Frame_Ack = 1'b0;
        bus.i_Rd_Addr   = '0;

        // Reset state
        #2;
        chk("rst_valid", 32'(bus.o_Frame_Valid), 32'd0);
        chk("rst_busy",  32'(bus.o_Busy),        32'd0);
        chk("rst_stb",   32'(bus.o_Err_Stb),     32'd0);
        chk("rst_len",   32'(bus.o_Frame_Len),   32'd0);
        chk("rst_code",  32'(bus.o_Err_Code),    32'd0);
        chk("rst_rd",    32'(bus.o_Rd_Data),     32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1: good 3-byte frame, read back, ack
        send(8'hA5);
        chk("t1_busy", 32'(bus.o_Busy), 32'd1);
        send(8'h03); send(8'h11); send(8'h22); send(8'h33);
        chk("t1_novalid_early", 32'(bus.o_Frame_Valid), 32'd0);
        send(8'h69);
        chk("t1_valid", 32'(bus.o_Frame_Valid), 32'd1);
        chk("t1_len",   32'(bus.o_Frame_Len),   32'd3);
        chk("t1_stb",   32'(bus.o_Err_Stb),     32'd0);
        rd("t1_rd0", 4'd0, 8'h11);
        rd("t1_rd1", 4'd1, 8'h22);
        rd("t1_rd2", 4'd2, 8'h33);
        ack();
        chk("t1_ack_valid", 32'(bus.o_Frame_Valid), 32'd0);
        chk("t1_ack_busy",  32'(bus.o_Busy),        32'd0);

        // 2: bad checksum, then a good 1-byte frame
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h6A);
        chk("t2_stb",   32'(bus.o_Err_Stb),     32'd1);
        chk("t2_code",  32'(bus.o_Err_Code),    32'd0);
        chk("t2_valid", 32'(bus.o_Frame_Valid), 32'd0);
        @(negedge clk);
        chk("t2_stb_1cyc", 32'(bus.o_Err_Stb), 32'd0);
        chk("t2_busy",     32'(bus.o_Busy),    32'd0);
        send(8'hA5); send(8'h01); send(8'h7F); send(8'h80);
        chk("t2_valid2", 32'(bus.o_Frame_Valid), 32'd1);
        chk("t2_len2",   32'(bus.o_Frame_Len),   32'd1);
        rd("t2_rd0", 4'd0, 8'h7F);
        ack();

        // 3: length zero, length over max, length exactly max
        send(8'hA5); send(8'h00);
        chk("t3_zero_stb",  32'(bus.o_Err_Stb),  32'd1);
        chk("t3_zero_code", 32'(bus.o_Err_Code), 32'd1);
        chk("t3_zero_busy", 32'(bus.o_Busy),     32'd0);
        send(8'hA5); send(8'h11);
        chk("t3_big_stb",  32'(bus.o_Err_Stb),  32'd1);
        chk("t3_big_code", 32'(bus.o_Err_Code), 32'd1);
        chk("t3_big_busy", 32'(bus.o_Busy),     32'd0);
        send(8'hA5); send(8'h10);
        for (int i = 0; i < 16; i++) send(8'(i));
        send(8'h88);
        chk("t3_max_valid", 32'(bus.o_Frame_Valid), 32'd1);
        chk("t3_max_len",   32'(bus.o_Frame_Len),   32'd16);
        rd("t3_max_rd15", 4'd15, 8'h0F);
        ack();

        // 4: timeout 8 cycles after the LEN strobe, and a byte on cycle 8 averting it
        send(8'hA5); send(8'h02);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("t4_no_early_stb", 32'(bus.o_Err_Stb), 32'd0);
        end
        @(negedge clk);
        chk("t4_tmo_stb",  32'(bus.o_Err_Stb),  32'd1);
        chk("t4_tmo_code", 32'(bus.o_Err_Code), 32'd2);
        chk("t4_tmo_busy", 32'(bus.o_Busy),     32'd0);
        send(8'hA5); send(8'h02);
        for (int i = 0; i < 6; i++) @(negedge clk);
        send(8'h10);
        chk("t4_edge_stb",  32'(bus.o_Err_Stb), 32'd0);
        chk("t4_edge_busy", 32'(bus.o_Busy),    32'd1);
        send(8'h20); send(8'h32);
        chk("t4_edge_valid", 32'(bus.o_Frame_Valid), 32'd1);
        rd("t4_edge_rd0", 4'd0, 8'h10);
        ack();

        // 5: junk before SYNC is silent; byte during HOLD is an overrun
        snap = err_pulses;
        send(8'h00); send(8'hFF); send(8'h5A);
        chk("t5_junk_busy", 32'(bus.o_Busy), 32'd0);
        chk("t5_junk_errs", 32'(err_pulses), 32'(snap));
        send(8'hA5); send(8'h02); send(8'hAB); send(8'hCD); send(8'h7A);
        chk("t5_valid", 32'(bus.o_Frame_Valid), 32'd1);
        send(8'h55);
        chk("t5_ovr_stb",   32'(bus.o_Err_Stb),     32'd1);
        chk("t5_ovr_code",  32'(bus.o_Err_Code),    32'd3);
        chk("t5_ovr_valid", 32'(bus.o_Frame_Valid), 32'd1);
        chk("t5_ovr_len",   32'(bus.o_Frame_Len),   32'd2);
        rd("t5_rd0", 4'd0, 8'hAB);
        rd("t5_rd1", 4'd1, 8'hCD);
        ack();

        // 6: reset mid-frame clears outputs asynchronously, next frame is clean
        send(8'hA5); send(8'h04); send(8'h11);
        chk("t6_busy_pre", 32'(bus.o_Busy), 32'd1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_busy",  32'(bus.o_Busy),        32'd0);
        chk("t6_rst_valid", 32'(bus.o_Frame_Valid), 32'd0);
        chk("t6_rst_len",   32'(bus.o_Frame_Len),   32'd0);
        chk("t6_rst_code",  32'(bus.o_Err_Code),    32'd0);
        chk("t6_rst_rd",    32'(bus.o_Rd_Data),     32'd0);
        chk("t6_rst_stb",   32'(bus.o_Err_Stb),     32'd0);
        @(negedge clk);
        rst = 1'b0;
        send(8'hA5); send(8'h01); send(8'h42); send(8'h43);
        chk("t6_valid", 32'(bus.o_Frame_Valid), 32'd1);
        chk("t6_len",   32'(bus.o_Frame_Len),   32'd1);
        rd("t6_rd0", 4'd0, 8'h42);
        ack();

        // CHK, 2x LEN, TIMEOUT, OVERRUN
        chk("total_err_pulses", 32'(err_pulses), 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
